// File: rtl/byte_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : byte_sequencer_pkg
// Purpose  : Shared state encoding and default dwell constant for byte_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package byte_sequencer_pkg;

    // 1 s per slot at 50 MHz
    localparam int unsigned c_DWELL_DEFAULT = 32'd50000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : byte_sequencer_pkg
`default_nettype wire

// File: rtl/byte_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : byte_sequencer_if
// Purpose  : Control, selector and playback signals of byte_sequencer.
//            Optional loop input when BYTE_SEQUENCER_LOOP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface byte_sequencer_if;
    logic       start;
    logic       pause;
    logic [1:0] last;
    logic [7:0] mux_data;
    logic [1:0] sel;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       busy;
    logic       done;
`ifdef BYTE_SEQUENCER_LOOP_EN
    logic       loop;

    modport master (
        output start, pause, last, mux_data, loop,
        input  sel, byte_out, byte_valid, busy, done
    );
    modport slave (
        input  start, pause, last, mux_data, loop,
        output sel, byte_out, byte_valid, busy, done
    );
`else
    modport master (
        output start, pause, last, mux_data,
        input  sel, byte_out, byte_valid, busy, done
    );
    modport slave (
        input  start, pause, last, mux_data,
        output sel, byte_out, byte_valid, busy, done
    );
`endif
endinterface : byte_sequencer_if
`default_nettype wire

// File: rtl/byte_sequencer_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : dwell_timer
// Purpose  : TW-bit slot dwell counter; terminal flags count == DWELL-1.
// Revision : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int unsigned DWELL = 32'd50000000,
    parameter int unsigned TW    = 32
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      terminal
);

    localparam logic [TW-1:0] c_TERM = TW'(DWELL - 32'd1);

    logic [TW-1:0] r_count;

    // clear wins over enable so every slot starts from zero
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign terminal = (r_count == c_TERM);

endmodule : dwell_timer
`default_nettype wire

// File: rtl/byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : byte_sequencer
// Purpose  : Walks a 4-way byte selector through slots 0..last, capturing and
//            holding each byte for DWELL cycles. BYTE_SEQUENCER_LOOP_EN adds
//            continuous replay via the loop input.
// Revision : 1.0 - initial release
// ============================================================================
module byte_sequencer
    import byte_sequencer_pkg::*;
#(
    parameter int unsigned DWELL = c_DWELL_DEFAULT,
    parameter int unsigned TW    = 32
) (
    input  wire logic        clock,
    input  wire logic        reset,
    byte_sequencer_if.slave  bus
);

    state_t     r_state;
    logic [1:0] r_sel;
    logic [1:0] r_last_q;
    logic [7:0] r_byte_out;
    logic       r_byte_valid;
    logic       r_busy;
    logic       r_done;

    logic       w_term;
    logic       w_advance;
    logic       w_loop;

`ifdef BYTE_SEQUENCER_LOOP_EN
    assign w_loop = bus.loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_advance = (r_state == ST_SHOW) && w_term && !bus.pause;

    dwell_timer #(
        .DWELL (DWELL),
        .TW    (TW)
    ) u_dwell_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (r_state == ST_LOAD),
        .enable   ((r_state == ST_SHOW) && !bus.pause),
        .terminal (w_term)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sel        <= 2'd0;
            r_last_q     <= 2'd0;
            r_byte_out   <= 8'd0;
            r_byte_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_last_q <= bus.last;
                        r_sel    <= 2'd0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // sel has been stable for a full cycle, so mux_data is settled
                    r_byte_out   <= bus.mux_data;
                    r_byte_valid <= 1'b1;
                    r_state      <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (w_advance) begin
                        if (r_sel != r_last_q) begin
                            r_sel   <= r_sel + 2'd1;
                            r_state <= ST_LOAD;
                        end else if (w_loop) begin
                            r_sel   <= 2'd0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel        = r_sel;
    assign bus.byte_out   = r_byte_out;
    assign bus.byte_valid = r_byte_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule : byte_sequencer
`default_nettype wire

// File: tb/tb_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_sequencer
// Purpose  : Directed self-checking bench for byte_sequencer with DWELL=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_sequencer;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    byte_sequencer_if ifc ();

    logic [7:0] r_table [4];
    assign ifc.mux_data = r_table[ifc.sel];

    byte_sequencer #(
        .DWELL (3),
        .TW    (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, " quiet valid"}, {31'd0, ifc.byte_valid}, 32'd0);
            chk({tag, " quiet done"},  {31'd0, ifc.done}, 32'd0);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [1:0] slot, input logic [7:0] val);
        tick();
        chk({tag, " valid"}, {31'd0, ifc.byte_valid}, 32'd1);
        chk({tag, " byte"},  {24'd0, ifc.byte_out}, {24'd0, val});
        chk({tag, " sel"},   {30'd0, ifc.sel}, {30'd0, slot});
        chk({tag, " busy"},  {31'd0, ifc.busy}, 32'd1);
    endtask

    task automatic expect_done(input string tag);
        tick();
        chk({tag, " done"}, {31'd0, ifc.done}, 32'd1);
        chk({tag, " busy"}, {31'd0, ifc.busy}, 32'd0);
        tick();
        chk({tag, " done one cycle"}, {31'd0, ifc.done}, 32'd0);
        chk({tag, " idle busy"},      {31'd0, ifc.busy}, 32'd0);
    endtask

    task automatic accept(input string tag, input logic [1:0] lst);
        ifc.last  = lst;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        chk({tag, " accept busy"},  {31'd0, ifc.busy}, 32'd1);
        chk({tag, " accept sel"},   {30'd0, ifc.sel}, 32'd0);
        chk({tag, " accept valid"}, {31'd0, ifc.byte_valid}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        r_table[0] = 8'hA0;
        r_table[1] = 8'hB1;
        r_table[2] = 8'hC2;
        r_table[3] = 8'hD3;
        ifc.start = 1'b0;
        ifc.pause = 1'b0;
        ifc.last  = 2'd0;
`ifdef BYTE_SEQUENCER_LOOP_EN
        ifc.loop  = 1'b0;
`endif
        reset = 1'b1;
        tick();
        tick();
        chk("reset sel",   {30'd0, ifc.sel}, 32'd0);
        chk("reset byte",  {24'd0, ifc.byte_out}, 32'd0);
        chk("reset valid", {31'd0, ifc.byte_valid}, 32'd0);
        chk("reset busy",  {31'd0, ifc.busy}, 32'd0);
        chk("reset done",  {31'd0, ifc.done}, 32'd0);
        reset = 1'b0;
        expect_quiet("idle", 2);

        // basic run: bytes at edges 2,6,10,14 after accept, done at 17
        accept("basic", 2'd3);
        expect_byte("basic s0", 2'd0, 8'hA0);
        expect_quiet("basic s0", 3);
        expect_byte("basic s1", 2'd1, 8'hB1);
        expect_quiet("basic s1", 3);
        expect_byte("basic s2", 2'd2, 8'hC2);
        expect_quiet("basic s2", 3);
        expect_byte("basic s3", 2'd3, 8'hD3);
        expect_quiet("basic s3", 2);
        expect_done("basic");
        chk("basic final sel",  {30'd0, ifc.sel}, 32'd3);
        chk("basic final byte", {24'd0, ifc.byte_out}, 32'hD3);

        // short run: done 5 edges after accept
        accept("short", 2'd0);
        expect_byte("short s0", 2'd0, 8'hA0);
        expect_quiet("short s0", 2);
        expect_done("short");
        chk("short sel", {30'd0, ifc.sel}, 32'd0);

        // pause 5 cycles in slot 0: B1 at edge 11, done at 14
        accept("pause", 2'd1);
        expect_byte("pause s0", 2'd0, 8'hA0);
        ifc.pause = 1'b1;
        expect_quiet("pause held", 5);
        ifc.pause = 1'b0;
        expect_quiet("pause s0", 3);
        expect_byte("pause s1", 2'd1, 8'hB1);
        expect_quiet("pause s1", 2);
        expect_done("pause");

        // start held and last changed mid-run are ignored
        accept("ignore", 2'd2);
        ifc.start = 1'b1;
        ifc.last  = 2'd0;
        expect_byte("ignore s0", 2'd0, 8'hA0);
        expect_quiet("ignore s0", 3);
        expect_byte("ignore s1", 2'd1, 8'hB1);
        expect_quiet("ignore s1", 3);
        expect_byte("ignore s2", 2'd2, 8'hC2);
        ifc.start = 1'b0;
        expect_quiet("ignore s2", 2);
        expect_done("ignore");
        expect_quiet("ignore after", 4);

        // reset during slot 1 SHOW
        accept("abort", 2'd3);
        expect_byte("abort s0", 2'd0, 8'hA0);
        expect_quiet("abort s0", 3);
        expect_byte("abort s1", 2'd1, 8'hB1);
        expect_quiet("abort s1", 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort sel",   {30'd0, ifc.sel}, 32'd0);
        chk("abort byte",  {24'd0, ifc.byte_out}, 32'd0);
        chk("abort busy",  {31'd0, ifc.busy}, 32'd0);
        chk("abort done",  {31'd0, ifc.done}, 32'd0);
        expect_quiet("abort after", 6);
        chk("abort idle busy", {31'd0, ifc.busy}, 32'd0);
        accept("rerun", 2'd1);
        expect_byte("rerun s0", 2'd0, 8'hA0);
        expect_quiet("rerun s0", 3);
        expect_byte("rerun s1", 2'd1, 8'hB1);
        expect_quiet("rerun s1", 2);
        expect_done("rerun");

`ifdef BYTE_SEQUENCER_LOOP_EN
        ifc.loop = 1'b1;
        accept("loop", 2'd1);
        expect_byte("loop p0 s0", 2'd0, 8'hA0);
        expect_quiet("loop p0 s0", 3);
        expect_byte("loop p0 s1", 2'd1, 8'hB1);
        expect_quiet("loop p0 s1", 3);
        expect_byte("loop p1 s0", 2'd0, 8'hA0);
        expect_quiet("loop p1 s0", 3);
        expect_byte("loop p1 s1", 2'd1, 8'hB1);
        ifc.loop = 1'b0;
        expect_quiet("loop p1 s1", 2);
        expect_done("loop");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_byte_sequencer
`default_nettype wire
